// File: rtl/pwm_diag_decoder.sv
// pwm_diag_decoder: decodes a duty-encoded PWM diagnostic line into a 3-bit code
// (0..7, or 8 for an error-level duty). It also flags a line that is stuck high or
// stuck low.
//
// Parameters:
//   KBAUD    - nominal frame period in clk cycles
//   CNT_BITS - width of the high/low/period counters
//
// Ports:
//   clk, rst_n  - system clock (rising edge), async active-low reset
//   pwm_in      - asynchronous PWM input
//   data_out    - last decoded code (0..8), held between updates
//   data_valid  - one-cycle pulse when data_out updates
//   code_err    - set with data_out when the code is 8
//   stuck_err   - level; line stuck high or low; clears on the next normal decode
//   period_err  - one-cycle pulse on an out-of-tolerance rise-to-rise period
//
// Optional feature: define PWM_DEC_PERIOD_CHECK_EN to build the period checker.
// Without it, period_err is tied to 0.
module pwm_diag_decoder #(
  parameter int unsigned KBAUD    = 14'd10416,
  parameter int unsigned CNT_BITS = $clog2(2 * KBAUD) + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwm_in,
  output logic [3:0] data_out,
  output logic       data_valid,
  output logic       code_err,
  output logic       stuck_err,
  output logic       period_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  localparam int unsigned NUM_BND = 8;
  localparam int unsigned BND [NUM_BND] = '{
    $rtoi(KBAUD * 0.125), $rtoi(KBAUD * 0.25), $rtoi(KBAUD * 0.35), $rtoi(KBAUD * 0.45),
    $rtoi(KBAUD * 0.55),  $rtoi(KBAUD * 0.65), $rtoi(KBAUD * 0.75), $rtoi(KBAUD * 0.875)
  };
  localparam int unsigned LOW_TO = 2 * KBAUD;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (v == '1) ? v : v + CNT_BITS'(1);
  endfunction

  // Two-flop synchronizer plus a delayed copy for edge detection.
  logic       pwm_m, pwm_s, pwm_d;
  // The pipeline holds reset values for its first cycles. Edges are qualified
  // only after every stage holds a real sample, so a line that is already high
  // at reset release cannot fake a rising edge.
  logic [1:0] warm_q;
  logic       warm_ok, rise, fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_m  <= 1'b0;
      pwm_s  <= 1'b0;
      pwm_d  <= 1'b0;
      warm_q <= 2'd0;
    end else begin
      pwm_m <= pwm_in;
      pwm_s <= pwm_m;
      pwm_d <= pwm_s;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end

  assign warm_ok = (warm_q == 2'd3);
  assign rise    = warm_ok & pwm_s & ~pwm_d;
  assign fall    = warm_ok & ~pwm_s & pwm_d;

  logic [1:0]          state_q, state_d;
  logic [CNT_BITS-1:0] h_q, h_d;
  logic [CNT_BITS-1:0] l_q, l_d;
  logic [3:0]          dout_q, dout_d;
  logic                dv_q, dv_d;
  logic                cerr_q, cerr_d;
  logic                stuck_q, stuck_d;
  logic [3:0]          code;

  // Code is the number of boundaries at or below the measured high time.
  always_comb begin
    code = 4'd0;
    for (int i = 0; i < NUM_BND; i++) begin
      code = code + 4'(h_q >= CNT_BITS'(BND[i]));
    end
  end

  // State register and output/measurement registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      l_q     <= '0;
      dout_q  <= 4'd0;
      dv_q    <= 1'b0;
      cerr_q  <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      l_q     <= l_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      cerr_q  <= cerr_d;
      stuck_q <= stuck_d;
    end
  end

  // Next-state logic. A rising edge is tested before any low-side timeout, so
  // an edge that arrives in the timeout cycle still starts a new frame.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    l_d     = l_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    cerr_d  = cerr_q;
    stuck_d = stuck_q;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_HIGH;
          h_d     = CNT_BITS'(1);
        end else begin
          l_d = sat_inc(l_q);
          if (l_q >= CNT_BITS'(LOW_TO)) stuck_d = 1'b1;
        end
      end
      S_HIGH: begin
        if (fall) begin
          state_d = S_LOW;
          l_d     = CNT_BITS'(1);
          dout_d  = code;
          dv_d    = 1'b1;
          cerr_d  = (code == 4'd8);
          stuck_d = 1'b0;
        end else if (h_q >= CNT_BITS'(KBAUD)) begin
          state_d = S_IDLE;
          stuck_d = 1'b1;
          l_d     = '0;
        end else begin
          h_d = sat_inc(h_q);
        end
      end
      S_LOW: begin
        if (rise) begin
          state_d = S_HIGH;
          h_d     = CNT_BITS'(1);
        end else if (l_q >= CNT_BITS'(LOW_TO)) begin
          state_d = S_IDLE;
          stuck_d = 1'b1;
        end else begin
          l_d = sat_inc(l_q);
        end
      end
      default: begin
        state_d = S_IDLE;
        l_d     = '0;
      end
    endcase
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign code_err   = cerr_q;
  assign stuck_err  = stuck_q;

`ifdef PWM_DEC_PERIOD_CHECK_EN
  localparam int unsigned PER_MIN = $rtoi(KBAUD * 0.97);
  localparam int unsigned PER_MAX = $rtoi(KBAUD * 1.03);

  logic [CNT_BITS-1:0] p_q;
  logic                perr_q;

  // Rise-to-rise period. Only a rise out of LOW closes a measured period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q    <= '0;
      perr_q <= 1'b0;
    end else begin
      p_q    <= rise ? CNT_BITS'(1) : sat_inc(p_q);
      perr_q <= rise && (state_q == S_LOW) &&
                ((p_q < CNT_BITS'(PER_MIN)) || (p_q > CNT_BITS'(PER_MAX)));
    end
  end

  assign period_err = perr_q;
`else
  assign period_err = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_diag_decoder.sv
// Directed bench for pwm_diag_decoder with KBAUD=100.
// Boundaries are 12, 25, 35, 45, 55, 65, 75 and 87, and the period window is 97..103.
module tb_pwm_diag_decoder;

  localparam int unsigned KB = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pwm_in;
  logic [3:0] data_out;
  logic       data_valid;
  logic       code_err;
  logic       stuck_err;
  logic       period_err;

  int n_cmp = 0;
  int n_err = 0;
  int dv_cnt = 0;
  int pe_cnt = 0;
  int dv_mark;
  int pe_mark;

  pwm_diag_decoder #(.KBAUD(KB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .code_err  (code_err),
    .stuck_err (stuck_err),
    .period_err(period_err)
  );

  always #5 clk = ~clk;

  // Count pulse cycles. A single-cycle pulse counts exactly once.
  always @(negedge clk) begin
    if (data_valid === 1'b1) dv_cnt++;
    if (period_err === 1'b1) pe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input int hi, input int lo);
    hold(1'b1, hi);
    hold(1'b0, lo);
  endtask

  int hi_t [4] = '{11, 12, 25, 87};
  int exp_c[4] = '{0, 1, 2, 8};
  int exp_pe;

  initial begin
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_data_valid", 32'(data_valid), 0);
    check("rst_code_err", 32'(code_err), 0);
    check("rst_stuck_err", 32'(stuck_err), 0);
    check("rst_period_err", 32'(period_err), 0);
    rst_n = 1'b1;
    hold(1'b0, 10);

    // 40/60 frames decode to 3, one pulse per frame.
    for (int i = 0; i < 3; i++) begin
      dv_mark = dv_cnt;
      frame(40, 60);
      check("f40_dv_count", 32'(dv_cnt - dv_mark), 1);
      check("f40_data_out", 32'(data_out), 3);
      check("f40_code_err", 32'(code_err), 0);
    end
    check("f40_stuck", 32'(stuck_err), 0);

    // High time boundaries, each frame still 100 cycles long.
    for (int i = 0; i < 4; i++) begin
      dv_mark = dv_cnt;
      frame(hi_t[i], 100 - hi_t[i]);
      check("bnd_dv_count", 32'(dv_cnt - dv_mark), 1);
      check("bnd_data_out", 32'(data_out), 32'(exp_c[i]));
      check("bnd_code_err", 32'(code_err), (exp_c[i] == 8) ? 1 : 0);
    end

    // Stuck high: no error before h reaches 100, then an error and no decode.
    dv_mark = dv_cnt;
    hold(1'b1, 90);
    check("sh_early_stuck", 32'(stuck_err), 0);
    check("sh_hold_code", 32'(data_out), 8);
    hold(1'b1, 60);
    check("sh_stuck", 32'(stuck_err), 1);
    check("sh_no_dv", 32'(dv_cnt - dv_mark), 0);
    hold(1'b0, 40);
    dv_mark = dv_cnt;
    frame(60, 40);
    check("sh_rec_dv", 32'(dv_cnt - dv_mark), 1);
    check("sh_rec_data", 32'(data_out), 5);
    check("sh_rec_stuck", 32'(stuck_err), 0);

    // Stuck low: the line has been low 40 cycles already. After 190 there is
    // no error yet; after 250 the error is set.
    dv_mark = dv_cnt;
    hold(1'b0, 150);
    check("sl_early_stuck", 32'(stuck_err), 0);
    hold(1'b0, 60);
    check("sl_stuck", 32'(stuck_err), 1);
    check("sl_no_dv", 32'(dv_cnt - dv_mark), 0);
    frame(40, 60);
    check("sl_rec_data", 32'(data_out), 3);
    check("sl_rec_stuck", 32'(stuck_err), 0);

    // Period check. A 100-cycle period is in tolerance. A 110-cycle period
    // pulses period_err at the closing rise, and only when the check is built in.
`ifdef PWM_DEC_PERIOD_CHECK_EN
    exp_pe = 1;
`else
    exp_pe = 0;
`endif
    pe_mark = pe_cnt;
    frame(40, 60);
    check("per100_err", 32'(pe_cnt - pe_mark), 0);
    frame(40, 70);
    pe_mark = pe_cnt;
    frame(40, 60);
    check("per110_err", 32'(pe_cnt - pe_mark), 32'(exp_pe));
    check("per110_data", 32'(data_out), 3);
    check("per_total", 32'(pe_cnt), 32'(exp_pe));

    // Reset at h=30: outputs clear, and the partial pulse is not decoded.
    hold(1'b1, 30);
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_data_out", 32'(data_out), 0);
    check("mr_data_valid", 32'(data_valid), 0);
    check("mr_code_err", 32'(code_err), 0);
    check("mr_stuck", 32'(stuck_err), 0);
    check("mr_period", 32'(period_err), 0);
    hold(1'b1, 2);
    rst_n = 1'b1;
    dv_mark = dv_cnt;
    hold(1'b1, 30);
    hold(1'b0, 60);
    check("mr_partial_dv", 32'(dv_cnt - dv_mark), 0);
    check("mr_partial_data", 32'(data_out), 0);
    frame(25, 75);
    check("mr_first_dv", 32'(dv_cnt - dv_mark), 1);
    check("mr_first_data", 32'(data_out), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_diag_decoder.md
PWM_DIAG_DECODER -- requirements
Module: pwm_diag_decoder

Interface
REQ-001 SHALL have parameter KBAUD, default 14'd10416: nominal PWM frame period in clk cycles.
REQ-002 SHALL have parameter CNT_BITS, default $clog2(2*KBAUD)+1: width of internal high, low and period counters.
REQ-003 SHALL have port clk, input, 1: single system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port pwm_in, input, 1: asynchronous PWM line carrying one 3-bit diagnostic code per frame, duty-encoded.
REQ-006 SHALL have port data_out, output, 4: last decoded code, 0..7 valid, 8 means error level.
REQ-007 SHALL have port data_valid, output, 1: one-cycle pulse when data_out is updated.
REQ-008 SHALL have port code_err, output, 1: registered with data_out, 1 when the decoded code is 8.
REQ-009 SHALL have port stuck_err, output, 1: level, line stuck high or stuck low.
REQ-010 SHALL have port period_err, output, 1: one-cycle pulse on out-of-tolerance frame period; tied 0 when the feature is compiled out.

Function
REQ-011 SHALL pass pwm_in through a 2-FF synchronizer; all edge detection SHALL use the synchronized signal (pwm_s).
REQ-012 SHALL define boundaries B0..B7 = $rtoi(KBAUD*{0.125,0.25,0.35,0.45,0.55,0.65,0.75,0.875}).
REQ-013 SHALL implement states IDLE (waiting for first rise), HIGH (counting high time h), LOW (counting low time, waiting for next rise).
REQ-014 IDLE->HIGH on pwm_s rising edge; h cleared to 1 on entry.
REQ-015 HIGH->LOW on pwm_s falling edge; the decoded code SHALL equal the count of boundaries Bi <= h (0..8).
REQ-016 The cycle after the falling edge is detected, data_out SHALL update, data_valid SHALL pulse, and code_err SHALL equal (code==8).
REQ-017 LOW->HIGH on pwm_s rising edge; a new h measurement SHALL start on that same edge cycle.
REQ-018 In HIGH, if h reaches KBAUD without a falling edge, state SHALL go to IDLE, stuck_err SHALL set, and no data_valid SHALL be generated.
REQ-019 In LOW or IDLE, if 2*KBAUD cycles elapse without a rising edge, stuck_err SHALL set and state SHALL be IDLE.
REQ-020 stuck_err SHALL clear on the next complete high pulse that is decoded normally.
REQ-021 Counters SHALL saturate at 2^CNT_BITS-1 and never wrap.
REQ-022 data_out and code_err SHALL hold their values between data_valid pulses.
REQ-023 A rising edge and a timeout in the same cycle: the edge SHALL win and no stuck_err SHALL be raised.

Reset
REQ-024 On rst_n low, the synchronizer SHALL clear to 0 and state SHALL go to IDLE.
REQ-025 On rst_n low, all counters and data_out SHALL go to 0, and data_valid, code_err, stuck_err and period_err SHALL go to 0.
REQ-026 Reset asserted mid-frame SHALL discard the partial measurement; after release, decoding SHALL restart at the next rising edge.
REQ-027 No output SHALL pulse during the first partial frame after reset release.

Configuration
REQ-028 Macro PWM_DEC_PERIOD_CHECK_EN defined: the rise-to-rise period P SHALL be measured on every rising edge in LOW.
REQ-029 With the macro defined, P outside [$rtoi(KBAUD*0.97), $rtoi(KBAUD*1.03)] SHALL pulse period_err for one cycle on that edge, with the data path unaffected.
REQ-030 Macro undefined: the period counter SHALL be absent and period_err SHALL be constant 0.

Verification
REQ-031 KBAUD=100, frames of 40 high / 60 low repeated -> data_out=3, data_valid once per frame, code_err=0.
REQ-032 KBAUD=100, high times 11, 12, 25, 87 -> codes 0, 1, 2, 8 respectively; code_err=1 only for 87.
REQ-033 KBAUD=100, pwm_in held high 150 cycles -> stuck_err=1 at h=100, no data_valid; then a 60/40 frame -> data_out=5 and stuck_err=0.
REQ-034 KBAUD=100, pwm_in low 250 cycles after a frame -> stuck_err=1 at 200 cycles of low time.
REQ-035 rst_n pulsed low at h=30 of a frame -> all outputs 0, first data_valid only after the next complete high pulse.
REQ-036 With PWM_DEC_PERIOD_CHECK_EN, KBAUD=100, periods of 100 then 110 -> period_err pulse only at the rising edge ending the 110 period; without the macro, period_err stays 0.
